// File: rtl/config_stream_sequencer_pkg.sv
// Shared definitions for the configuration stream sequencer.
//   - sequencer FSM state encoding
//   - default chain count and word-count field width
//   - number of serial bits each chain receives per 32-bit word
package config_stream_sequencer_pkg;

    localparam int unsigned NCHAIN_DEF     = 4;
    localparam int unsigned LEN_W_DEF      = 8;
    localparam int unsigned BITS_PER_CHAIN = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_SHIFT,
        S_SET,
        S_DONE
    } state_e;

endpackage

// File: rtl/config_stream_sequencer_cfg_word_skid.sv
// One-entry holding buffer between the bitstream input and the shift register.
// Ports:
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   flush_i            empties the buffer on the next edge
//   in_valid_i/in_ready_o/in_data_i     upstream handshake (ready = empty)
//   out_valid_o/out_ready_i/out_data_o  downstream handshake (valid = full)
module cfg_word_skid
    import config_stream_sequencer_pkg::*;
#(
    parameter int unsigned DATA_W = NCHAIN_DEF * BITS_PER_CHAIN
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o
);

    logic              full_q, full_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              accept, drain;

    assign in_ready_o  = ~full_q;
    assign out_valid_o = full_q;
    assign out_data_o  = data_q;
    assign accept      = in_valid_i & in_ready_o;
    assign drain       = full_q & out_ready_i;

    // A drain and a fill in the same cycle leave the buffer full with the
    // new word, so nothing is lost or duplicated.
    always_comb begin
        full_d = full_q;
        data_d = data_q;
        if (drain) begin
            full_d = 1'b0;
        end
        if (accept) begin
            full_d = 1'b1;
            data_d = in_data_i;
        end
        if (flush_i) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
        end
    end

endmodule

// File: rtl/config_stream_sequencer.sv
// Streams 32-bit bitstream words into NCHAIN serial configuration chains
// (byte k of each word feeds chain k, LSB first), then strobes the chain
// latches and pulses done.
// Ports:
//   wb_clk_i, wb_rst_ni   clock, asynchronous active-low reset
//   start_i, len_i        begin a run of len_i words (ignored while busy)
//   abort_i               terminate the current run at once
//   word_valid_i/word_ready_o/word_data_i   bitstream word handshake
//   busy_o, done_o        run in progress / one-cycle completion pulse
//   words_done_o          words fully shifted in the current or last run
//   cen_o, shift_out, set_out   chain clock enable, serial data, latch strobe
module config_stream_sequencer
    import config_stream_sequencer_pkg::*;
#(
    parameter int unsigned NCHAIN = NCHAIN_DEF,
    parameter int unsigned LEN_W  = LEN_W_DEF
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_ni,
    input  logic              start_i,
    input  logic [LEN_W-1:0]  len_i,
    input  logic              abort_i,
    input  logic              word_valid_i,
    input  logic [31:0]       word_data_i,
    output logic              word_ready_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [LEN_W-1:0]  words_done_o,
    output logic              cen_o,
    output logic [NCHAIN-1:0] shift_out,
    output logic [NCHAIN-1:0] set_out
);

    localparam int unsigned IDX_W = $clog2(BITS_PER_CHAIN);

    state_e            state_q, state_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  acc_q, acc_d;
    logic [LEN_W-1:0]  wdone_q, wdone_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [31:0]       shreg_q, shreg_d;

    logic              buf_valid, buf_ready, skid_in_ready;
    logic [31:0]       buf_data;
    logic              accept, last_bit, last_word;
    logic [LEN_W:0]    wdone_inc;
    logic [31:0]       shreg_win;

    assign busy_o       = (state_q != S_IDLE);
    assign word_ready_o = busy_o & skid_in_ready & (acc_q < len_q) & ~abort_i;
    assign accept       = word_valid_i & word_ready_o;
    assign last_bit     = (idx_q == IDX_W'(BITS_PER_CHAIN - 1));
    // One bit wider than the counters so len = 2^LEN_W-1 compares without wrap.
    assign wdone_inc    = {1'b0, wdone_q} + {{LEN_W{1'b0}}, 1'b1};
    assign last_word    = (wdone_inc == {1'b0, len_q});
    // Buffer drains into the shift register from WAIT, or back-to-back at the
    // end of a word that is not the last one.
    assign buf_ready    = (state_q == S_WAIT) |
                          ((state_q == S_SHIFT) & last_bit & ~last_word);
    assign words_done_o = wdone_q;
    assign shreg_win    = shreg_q >> idx_q;

    cfg_word_skid #(
        .DATA_W (32)
    ) u_skid (
        .clk_i       (wb_clk_i),
        .rst_ni      (wb_rst_ni),
        .flush_i     (abort_i),
        .in_valid_i  (accept),
        .in_ready_o  (skid_in_ready),
        .in_data_i   (word_data_i),
        .out_valid_o (buf_valid),
        .out_ready_i (buf_ready),
        .out_data_o  (buf_data)
    );

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        acc_d   = acc_q;
        wdone_d = wdone_q;
        idx_d   = idx_q;
        shreg_d = shreg_q;

        if (accept) begin
            acc_d = acc_q + LEN_W'(1);
        end

        // Abort overrides everything: all run state is held, only the FSM
        // returns to IDLE (the buffer is flushed inside the skid).
        if (abort_i) begin
            state_d = S_IDLE;
            acc_d   = acc_q;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        len_d   = len_i;
                        acc_d   = '0;
                        wdone_d = '0;
                        state_d = (len_i != '0) ? S_WAIT : S_DONE;
                    end
                end
                S_WAIT: begin
                    if (buf_valid) begin
                        shreg_d = buf_data;
                        idx_d   = '0;
                        state_d = S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    idx_d = idx_q + IDX_W'(1);
                    if (last_bit) begin
                        wdone_d = wdone_inc[LEN_W-1:0];
                        if (last_word) begin
                            state_d = S_SET;
                        end else if (buf_valid) begin
                            shreg_d = buf_data;
                            idx_d   = '0;
                        end else begin
                            state_d = S_WAIT;
                        end
                    end
                end
                S_SET:   state_d = S_DONE;
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        cen_o     = 1'b0;
        done_o    = 1'b0;
        shift_out = '0;
        set_out   = '0;
        case (state_q)
            S_SHIFT: begin
                cen_o = 1'b1;
                for (int k = 0; k < NCHAIN; k++) begin
                    shift_out[k] = shreg_win[k*BITS_PER_CHAIN];
                end
            end
            S_SET: begin
                cen_o   = 1'b1;
                set_out = '1;
            end
            S_DONE:  done_o = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            acc_q   <= '0;
            wdone_q <= '0;
            idx_q   <= '0;
            shreg_q <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            acc_q   <= acc_d;
            wdone_q <= wdone_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
        end
    end

endmodule

// File: tb/tb_config_stream_sequencer.sv
module tb_config_stream_sequencer;

    localparam int NCH = 4;
    localparam int LW  = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start_i, abort_i, word_valid_i;
    logic [LW-1:0] len_i;
    logic [31:0]   word_data_i;
    logic          word_ready_o, busy_o, done_o, cen_o;
    logic [LW-1:0] words_done_o;
    logic [NCH-1:0] shift_out, set_out;

    always #5 clk = ~clk;

    config_stream_sequencer #(.NCHAIN(NCH), .LEN_W(LW)) dut (
        .wb_clk_i     (clk),
        .wb_rst_ni    (rst_n),
        .start_i      (start_i),
        .len_i        (len_i),
        .abort_i      (abort_i),
        .word_valid_i (word_valid_i),
        .word_data_i  (word_data_i),
        .word_ready_o (word_ready_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .words_done_o (words_done_o),
        .cen_o        (cen_o),
        .shift_out    (shift_out),
        .set_out      (set_out)
    );

    // kind: 0 = one shift cycle (val = expected shift_out), 1 = set strobe,
    // 2 = done pulse (val = expected words_done_o)
    typedef struct {
        int          kind;
        logic [31:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   hs_cnt = 0;
    int   done_cnt = 0;
    int   shift_cycles = 0;
    int   cur_run = 0;
    int   max_run = 0;
    bit   feed_stop = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Chain k receives byte k of the word, bit i on the i-th shift cycle.
    function automatic logic [3:0] chain_bits(input logic [31:0] w, input int i);
        logic [7:0] b;
        logic [3:0] r;
        for (int k = 0; k < 4; k++) begin
            b    = w[8*k +: 8];
            r[k] = b[i];
        end
        return r;
    endfunction

    task automatic push_exp(input int kind, input logic [31:0] val);
        exp_t e;
        e.kind = kind;
        e.val  = val;
        exp_q.push_back(e);
    endtask

    task automatic push_word(input logic [31:0] w, input int nbits);
        for (int i = 0; i < nbits; i++) push_exp(0, {28'b0, chain_bits(w, i)});
    endtask

    task automatic push_run(input logic [31:0] w[$]);
        foreach (w[i]) push_word(w[i], 8);
        if (w.size() > 0) push_exp(1, 32'h0);
        push_exp(2, w.size());
    endtask

    task automatic take(input int kind, output logic [31:0] val, output bit ok);
        exp_t e;
        ok  = 0;
        val = 0;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_output: got event kind %0d required no event at %0t", kind, $time);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind) begin
                bad++;
                $display("FAIL event_order: got kind %0d required kind %0d at %0t", kind, e.kind, $time);
            end else begin
                ok  = 1;
                val = e.val;
            end
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents chain activity.
    always @(negedge clk) begin
        logic [31:0] v;
        bit          ok;
        if (rst_n) begin
            if (set_out != '0) begin
                take(1, v, ok);
                check("set_strobe", {cen_o, set_out}, 5'h1F);
                cur_run = 0;
            end else if (cen_o) begin
                shift_cycles++;
                take(0, v, ok);
                if (ok) check("shift_bits", shift_out, v[3:0]);
                cur_run++;
                if (cur_run > max_run) max_run = cur_run;
            end else begin
                cur_run = 0;
                check("idle_outputs", shift_out, 0);
            end
            if (done_o) begin
                done_cnt++;
                take(2, v, ok);
                if (ok) check("done_words", words_done_o, v);
                check("done_no_cen", cen_o, 0);
            end
        end
    end

    always @(negedge clk) begin
        #3;
        if (rst_n && word_valid_i && word_ready_o) hs_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no end of test required finish before %0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic start_pulse(input int len);
        @(negedge clk);
        start_i = 1'b1;
        len_i   = LW'(len);
        @(posedge clk);
        #1 start_i = 1'b0;
    endtask

    task automatic feed(input logic [31:0] w[$], input int gap);
        for (int i = 0; i < w.size(); i++) begin
            int tries;
            bit got;
            tries = 0;
            got   = 0;
            while (!got && !feed_stop) begin
                @(negedge clk);
                word_valid_i = ($urandom_range(99) >= gap);
                word_data_i  = word_valid_i ? w[i] : $urandom;
                #2;
                if (word_valid_i && word_ready_o) got = 1;
                tries++;
                if (tries > 3000 && !got) begin
                    check("feed_accept", got, 1);
                    feed_stop = 1;
                end
            end
        end
        @(negedge clk);
        word_valid_i = 1'b0;
    endtask

    task automatic wait_idle(input int bound);
        int n;
        n = 0;
        while (n < bound && (busy_o || exp_q.size() != 0)) begin
            @(negedge clk);
            #4;
            n++;
        end
        check("run_complete", {busy_o, exp_q.size() == 0}, 2'b01);
    endtask

    task automatic rand_words(input int n, output logic [31:0] w[$]);
        w = {};
        for (int i = 0; i < n; i++) w.push_back($urandom);
    endtask

    initial begin
        logic [31:0] w[$];
        logic [31:0] wa[$];
        logic [31:0] wb[$];
        int hs0, d0, n, len, gap;

        rst_n = 1'b0;
        start_i = 0; abort_i = 0; word_valid_i = 0; word_data_i = 0; len_i = 0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_busy", busy_o, 0);
        check("rst_done", done_o, 0);
        check("rst_cen", cen_o, 0);
        check("rst_shift", shift_out, 0);
        check("rst_set", set_out, 0);
        check("rst_ready", word_ready_o, 0);
        check("rst_words", words_done_o, 0);
        rst_n = 1'b1;

        // Single word offered continuously.
        w = {32'h80C0_E0F1};
        hs0 = hs_cnt; d0 = done_cnt;
        push_run(w);
        start_pulse(1);
        feed(w, 0);
        word_valid_i = 1'b1;
        word_data_i  = 32'h1234_5678;
        wait_idle(200);
        word_valid_i = 1'b0;
        check("len1_handshakes", hs_cnt - hs0, 1);
        check("len1_done_count", done_cnt - d0, 1);
        check("len1_words_done", words_done_o, 1);

        // Three words back to back: shifting must be continuous.
        rand_words(3, w);
        hs0 = hs_cnt; d0 = done_cnt; max_run = 0;
        push_run(w);
        start_pulse(3);
        feed(w, 0);
        word_valid_i = 1'b1;
        wait_idle(300);
        word_valid_i = 1'b0;
        check("len3_no_bubble", max_run, 24);
        check("len3_handshakes", hs_cnt - hs0, 3);
        check("len3_done_count", done_cnt - d0, 1);

        // Second word late: shifting pauses, resumes from bit 0.
        rand_words(2, w);
        wa = {w[0]};
        wb = {w[1]};
        max_run = 0;
        push_run(w);
        start_pulse(2);
        feed(wa, 0);
        repeat (13) @(negedge clk);
        feed(wb, 0);
        wait_idle(300);
        check("gap_split_runs", max_run, 8);
        check("gap_words_done", words_done_o, 2);

        // start while busy is ignored, length unchanged.
        rand_words(3, w);
        hs0 = hs_cnt;
        push_run(w);
        start_pulse(3);
        fork
            feed(w, 20);
            begin
                repeat (6) @(negedge clk);
                #1 start_i = 1'b1; len_i = 8'd7;
                @(negedge clk);
                #1 start_i = 1'b0;
            end
        join
        wait_idle(400);
        check("busy_start_handshakes", hs_cnt - hs0, 3);

        // Zero-length run goes straight to done.
        d0 = done_cnt; max_run = 0;
        push_exp(2, 0);
        start_pulse(0);
        wait_idle(20);
        check("len0_done_count", done_cnt - d0, 1);
        check("len0_no_cen", max_run, 0);

        // Abort at the 4th shift cycle of the second word of four.
        rand_words(4, w);
        push_word(w[0], 8);
        push_word(w[1], 4);
        feed_stop = 0; shift_cycles = 0; d0 = done_cnt;
        start_pulse(4);
        fork
            feed(w, 0);
            begin
                n = 0;
                while (shift_cycles < 12 && n < 400) begin
                    @(negedge clk);
                    #1;
                    n++;
                end
                check("abort_reached", shift_cycles, 12);
                abort_i = 1'b1;
                feed_stop = 1;
                @(negedge clk);
                #1 abort_i = 1'b0;
                check("abort_idle", busy_o, 0);
                check("abort_cen", cen_o, 0);
            end
        join
        check("abort_words_done", words_done_o, 1);
        check("abort_scoreboard_empty", exp_q.size(), 0);
        word_valid_i = 1'b1;
        repeat (3) begin
            @(negedge clk);
            #2;
            check("abort_ready_low", word_ready_o, 0);
        end
        word_valid_i = 1'b0;
        check("abort_no_done", done_cnt - d0, 0);
        feed_stop = 0;

        // abort and start together in IDLE: abort wins.
        @(negedge clk);
        start_i = 1'b1; abort_i = 1'b1; len_i = 8'd3;
        @(negedge clk);
        #1;
        check("abort_start_idle", busy_o, 0);
        start_i = 1'b0; abort_i = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_start_still_idle", busy_o, 0);

        // Maximum legal length.
        rand_words(255, w);
        hs0 = hs_cnt;
        push_run(w);
        start_pulse(255);
        feed(w, 0);
        wait_idle(4000);
        check("len255_handshakes", hs_cnt - hs0, 255);

        // Randomised runs.
        for (int r = 0; r < 12; r++) begin
            len = $urandom_range(0, 6);
            gap = $urandom_range(0, 70);
            rand_words(len, w);
            hs0 = hs_cnt;
            push_run(w);
            start_pulse(len);
            if (len > 0) feed(w, gap);
            wait_idle(3000);
            check("rand_handshakes", hs_cnt - hs0, len);
        end

        // Reset asserted in the middle of shifting.
        rand_words(2, w);
        push_run(w);
        feed_stop = 0; shift_cycles = 0;
        start_pulse(2);
        fork
            feed(w, 0);
            begin
                n = 0;
                while (shift_cycles < 3 && n < 200) begin
                    @(negedge clk);
                    #1;
                    n++;
                end
                #1 rst_n = 1'b0;
                #1;
                check("mid_rst_cen", cen_o, 0);
                check("mid_rst_shift", shift_out, 0);
                check("mid_rst_set", set_out, 0);
                check("mid_rst_busy", busy_o, 0);
                check("mid_rst_words", words_done_o, 0);
                feed_stop = 1;
                exp_q.delete();
                repeat (2) @(negedge clk);
                #1 rst_n = 1'b1;
            end
        join
        d0 = done_cnt;
        repeat (30) @(negedge clk);
        check("post_rst_no_done", done_cnt - d0, 0);
        check("post_rst_idle", busy_o, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
